bp_be_dcache_lce_mem_sched: RTL and testbench
=============================================

# bp_be_dcache_lce_mem_sched

Scheduler that owns the dcache tag_mem and stat_mem LCE write ports. After reset it sweeps every set, issuing set_clear to both memories. It then arbitrates the two LCE-side requesters for those ports: requester 0 is the CCE command handler, requester 1 is the fill/transfer handler. It sits between those handlers and the dcache, and it is the only block that drives tag_mem/stat_mem packets.

## Interface
Parameters:
- sets_p, 64, number of dcache sets; index width = `$clog2(sets_p)`
- ways_p, 8, associativity; way width = `$clog2(ways_p)`
- tag_width_p, 10, tag field width
- starve_limit_p, 4, consecutive requester-1 losses before requester 1 is forced to win

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- init_done_o  out  1  set sweep complete; requests may now be granted
- req_v_i  in  2  per-requester request valid
- req_tag_v_i  in  2  request carries a tag_mem packet
- req_stat_v_i  in  2  request carries a stat_mem packet
- req_tag_pkt_i  in  2 x tag_pkt_width  tag_mem packet per requester
- req_stat_pkt_i  in  2 x stat_pkt_width  stat_mem packet per requester
- req_yumi_o  out  2  request consumed this cycle (one-hot or zero)
- tag_mem_pkt_v_o  out  1  tag_mem packet valid
- tag_mem_pkt_o  out  tag_pkt_width  packet: opcode, index, way, tag
- tag_mem_ready_i  in  1  dcache tag_mem port free this cycle
- stat_mem_pkt_v_o  out  1  stat_mem packet valid
- stat_mem_pkt_o  out  stat_pkt_width  packet: opcode, index, way, lru_way
- stat_mem_ready_i  in  1  dcache stat_mem port free this cycle

## Operation
- FSM states: e_init, e_ready. Reset forces e_init, index counter = 0, starvation counter = 0.
- e_init:
  - Drive tag and stat packets with opcode set_clear, index = counter, way = 0, tag = 0.
  - Assert a packet valid only when both tag_mem_ready_i and stat_mem_ready_i are high. Both packets always issue together, never one alone.
  - Counter increments on each issue.
  - After the issue at index sets_p-1, move to e_ready.
  - req_yumi_o = 0 throughout.
- e_ready:
  - A request r is eligible when req_v_i[r] is high and every memory it needs has ready high: tag if req_tag_v_i[r], stat if req_stat_v_i[r].
  - A request with req_v_i high but neither tag_v nor stat_v is eligible and consumed without driving any packet.
  - Priority is requester 0, unless starve count == starve_limit_p, in which case requester 1 wins when eligible.
  - Winner: req_yumi_o[r] = 1. The needed packets are forwarded unmodified, with their valids set, in the same cycle. Tag and stat packets from a single request are atomic.
  - Starvation counter:
    - increments (saturating at starve_limit_p) when requester 1 is eligible but requester 0 wins;
    - clears when requester 1 wins or req_v_i[1] = 0.
- Opcode encodings: tag_mem {set_clear = 0, invalidate = 1, set_tag = 2}; stat_mem {set_clear = 0, read = 1, clear_dirty = 2, set_lru = 3}. The block does not interpret opcodes in e_ready.

## Timing
- Reset values: init_done_o = 0, all packet valids = 0, req_yumi_o = 0.
- Grant is combinational on inputs plus state: packets are valid in the same cycle as yumi, with no added latency.
- An asserted packet valid implies the matching ready is high that cycle, so the dcache accepts it unconditionally.
- Sweep takes exactly sets_p cycles when both readys stay high. Each cycle with either ready low stalls the sweep.
- init_done_o is registered. It rises the first cycle in e_ready (sweep length + 1 after reset release) and stays high until reset.
- reset_i asserted mid-sweep or mid-operation: the next cycle is in e_init with index 0, and the sweep restarts from set 0.
- A requester may hold req_v_i across cycles. Its packet must be stable until yumi.

## Structure
- Shared package bp_be_dcache_lce_pkg holds:
  - the tag/stat opcode enums;
  - bp_be_dcache_lce_tag_mem_pkt_s and bp_be_dcache_lce_stat_mem_pkt_s structs;
  - width macros parameterized by sets_p, ways_p, tag_width_p.
- One sub-module is natural: bp_be_dcache_lce_mem_sched_arb, the two-way priority picker with the starvation counter. The init FSM stays in the top.

## Test plan
- Sweep, sets_p = 64, both readys high: set_clear index 0..63 on consecutive cycles, init_done_o = 1 in cycle 65, no yumi before.
- Sweep stall: stat_mem_ready_i low for 3 cycles at index 10. Both valids are low for those cycles, index 10 is re-presented, and completion is delayed 3 cycles.
- Contention: both requesters request set_tag on every cycle with readys high.
  - requester 0 wins 4 cycles;
  - requester 1 wins cycle 5 and the count clears;
  - the pattern repeats.
- Partial readiness: requester 0 needs tag+stat, requester 1 needs tag only; stat_mem_ready_i = 0, tag ready = 1. Requester 1 is granted, and the stat packet valid stays 0.
- Reset mid-sweep at index 30: the cycle after reset shows index 0, init_done_o = 0, and the full sweep repeats.
- Empty request: req_v_i[0] = 1 with tag_v = stat_v = 0 gives yumi[0] = 1 and both packet valids 0.

Source files
------------

// File: rtl/bp_be_dcache_lce_pkg.sv
// bp_be_dcache_lce_pkg: shared opcodes, packet layouts and width macros for the dcache LCE write ports
`define BP_BE_DCACHE_LCE_TAG_MEM_PKT_WIDTH(sets_mp, ways_mp, tag_width_mp) (2+$clog2(sets_mp)+$clog2(ways_mp)+(tag_width_mp))
`define BP_BE_DCACHE_LCE_STAT_MEM_PKT_WIDTH(sets_mp, ways_mp) (2+$clog2(sets_mp)+2*$clog2(ways_mp))
package bp_be_dcache_lce_pkg;
  localparam int sets_lp = 64;
  localparam int ways_lp = 8;
  localparam int tag_width_lp = 10;
  typedef enum logic [1:0] {
    e_tag_set_clear  = 2'd0,
    e_tag_invalidate = 2'd1,
    e_tag_set_tag    = 2'd2
  } bp_be_dcache_lce_tag_op_e;
  typedef enum logic [1:0] {
    e_stat_set_clear   = 2'd0,
    e_stat_read        = 2'd1,
    e_stat_clear_dirty = 2'd2,
    e_stat_set_lru     = 2'd3
  } bp_be_dcache_lce_stat_op_e;
  typedef enum logic {e_init, e_ready} bp_be_dcache_lce_sched_state_e;
  typedef struct packed {
    bp_be_dcache_lce_tag_op_e       opcode;
    logic [$clog2(sets_lp)-1:0]     index;
    logic [$clog2(ways_lp)-1:0]     way;
    logic [tag_width_lp-1:0]        tag;
  } bp_be_dcache_lce_tag_mem_pkt_s;
  typedef struct packed {
    bp_be_dcache_lce_stat_op_e      opcode;
    logic [$clog2(sets_lp)-1:0]     index;
    logic [$clog2(ways_lp)-1:0]     way;
    logic [$clog2(ways_lp)-1:0]     lru_way;
  } bp_be_dcache_lce_stat_mem_pkt_s;
endpackage

// File: rtl/bp_be_dcache_lce_mem_sched_arb.sv
// bp_be_dcache_lce_mem_sched_arb: two-way fixed-priority picker that hands requester 1 a turn after starve_limit_p losses
module bp_be_dcache_lce_mem_sched_arb #(
  parameter int starve_limit_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic [1:0] elig_i,
  input  logic       v1_i,
  output logic [1:0] grant_o
);
  localparam int CW = $clog2(starve_limit_p + 1);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic          w_pri1;
  logic          w_g0;
  logic          w_g1;
  assign w_pri1 = r_cnt == CW'(starve_limit_p);
  assign w_g1 = en_i & elig_i[1] & (w_pri1 | ~elig_i[0]);
  assign w_g0 = en_i & elig_i[0] & ~w_g1;
  assign grant_o = {w_g1, w_g0};
  // requester 0 can only beat an eligible requester 1 below the limit, so the count saturates by itself
  always_comb w_cnt_n = !en_i ? r_cnt : (w_g1 | ~v1_i) ? '0 : (w_g0 & elig_i[1]) ? r_cnt + CW'(1) : r_cnt;
  always_ff @(posedge clk_i) begin
    if (reset_i) r_cnt <= '0;
    else r_cnt <= w_cnt_n;
  end
endmodule

// File: rtl/bp_be_dcache_lce_mem_sched.sv
// bp_be_dcache_lce_mem_sched: sole driver of dcache tag_mem/stat_mem LCE ports; clears every set after reset, then arbitrates two requesters
module bp_be_dcache_lce_mem_sched
  import bp_be_dcache_lce_pkg::*;
#(
  parameter int sets_p = 64,
  parameter int ways_p = 8,
  parameter int tag_width_p = 10,
  parameter int starve_limit_p = 4,
  localparam int tag_pkt_width_lp = `BP_BE_DCACHE_LCE_TAG_MEM_PKT_WIDTH(sets_p, ways_p, tag_width_p),
  localparam int stat_pkt_width_lp = `BP_BE_DCACHE_LCE_STAT_MEM_PKT_WIDTH(sets_p, ways_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  output logic                              init_done_o,
  input  logic [1:0]                        req_v_i,
  input  logic [1:0]                        req_tag_v_i,
  input  logic [1:0]                        req_stat_v_i,
  input  logic [1:0][tag_pkt_width_lp-1:0]  req_tag_pkt_i,
  input  logic [1:0][stat_pkt_width_lp-1:0] req_stat_pkt_i,
  output logic [1:0]                        req_yumi_o,
  output logic                              tag_mem_pkt_v_o,
  output logic [tag_pkt_width_lp-1:0]       tag_mem_pkt_o,
  input  logic                              tag_mem_ready_i,
  output logic                              stat_mem_pkt_v_o,
  output logic [stat_pkt_width_lp-1:0]      stat_mem_pkt_o,
  input  logic                              stat_mem_ready_i
);
  localparam int IW = $clog2(sets_p);
  localparam int WW = $clog2(ways_p);
  bp_be_dcache_lce_sched_state_e r_state;
  bp_be_dcache_lce_sched_state_e w_state_n;
  logic [IW-1:0] r_idx;
  logic          w_init;
  logic          w_issue;
  logic [1:0]    w_elig;
  logic [1:0]    w_grant;
  logic          w_sel;
  assign w_init = r_state == e_init;
  // both memories clear together so a set is never half-initialised
  assign w_issue = w_init & tag_mem_ready_i & stat_mem_ready_i;
  assign w_elig = req_v_i & (~req_tag_v_i | {2{tag_mem_ready_i}}) & (~req_stat_v_i | {2{stat_mem_ready_i}});
  assign w_sel = w_grant[1];
  assign init_done_o = r_state == e_ready;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_init;
      r_idx <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx <= r_idx + IW'(w_issue);
    end
  end
  always_comb w_state_n = (w_issue && r_idx == IW'(sets_p - 1)) ? e_ready : r_state;
  always_comb begin
    req_yumi_o = w_grant;
    tag_mem_pkt_v_o = w_init ? w_issue : |(w_grant & req_tag_v_i);
    stat_mem_pkt_v_o = w_init ? w_issue : |(w_grant & req_stat_v_i);
    tag_mem_pkt_o = w_init ? {e_tag_set_clear, r_idx, {(WW + tag_width_p){1'b0}}} : req_tag_pkt_i[w_sel];
    stat_mem_pkt_o = w_init ? {e_stat_set_clear, r_idx, {(2 * WW){1'b0}}} : req_stat_pkt_i[w_sel];
  end
  bp_be_dcache_lce_mem_sched_arb #(.starve_limit_p(starve_limit_p)) u_arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (r_state == e_ready),
    .elig_i (w_elig),
    .v1_i   (req_v_i[1]),
    .grant_o(w_grant)
  );
endmodule

// File: tb/tb_bp_be_dcache_lce_mem_sched.sv
// tb_bp_be_dcache_lce_mem_sched: table vectors, sweep/reset/contention sequences and random traffic against a counting reference model
module tb_bp_be_dcache_lce_mem_sched;
  import bp_be_dcache_lce_pkg::*;
  localparam int S = 64;
  localparam int LIM = 4;
  localparam int TW = `BP_BE_DCACHE_LCE_TAG_MEM_PKT_WIDTH(64, 8, 10);
  localparam int SW = `BP_BE_DCACHE_LCE_STAT_MEM_PKT_WIDTH(64, 8);
  localparam int TAG_SH = 3 + 10;
  localparam int STAT_SH = 3 + 3;
  typedef struct {
    logic [1:0] v, tv, sv;
    logic       tr, sr;
    logic [1:0] y;
    logic       etv, esv;
  } vec_t;
  logic clk = 0;
  logic reset_i;
  logic init_done_o;
  logic [1:0] req_v_i, req_tag_v_i, req_stat_v_i, req_yumi_o;
  logic [1:0][TW-1:0] req_tag_pkt_i;
  logic [1:0][SW-1:0] req_stat_pkt_i;
  logic tag_mem_pkt_v_o, stat_mem_pkt_v_o, tag_mem_ready_i, stat_mem_ready_i;
  logic [TW-1:0] tag_mem_pkt_o;
  logic [SW-1:0] stat_mem_pkt_o;
  int vectors = 0;
  int miscompares = 0;
  int m_issued = 0;
  int m_starve = 0;
  logic [1:0] a_y;
  logic a_tv, a_sv;
  vec_t tbl[10];
  always #5 clk = ~clk;
  bp_be_dcache_lce_mem_sched dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
    .req_v_i(req_v_i), .req_tag_v_i(req_tag_v_i), .req_stat_v_i(req_stat_v_i),
    .req_tag_pkt_i(req_tag_pkt_i), .req_stat_pkt_i(req_stat_pkt_i), .req_yumi_o(req_yumi_o),
    .tag_mem_pkt_v_o(tag_mem_pkt_v_o), .tag_mem_pkt_o(tag_mem_pkt_o), .tag_mem_ready_i(tag_mem_ready_i),
    .stat_mem_pkt_v_o(stat_mem_pkt_v_o), .stat_mem_pkt_o(stat_mem_pkt_o), .stat_mem_ready_i(stat_mem_ready_i)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic rnd_pkts();
    for (int r = 0; r < 2; r++) begin
      req_tag_pkt_i[r] = TW'($urandom);
      req_stat_pkt_i[r] = SW'($urandom);
    end
  endtask
  // one clock: drive, compare against the model, then advance the model past the edge
  task automatic cycle(input logic rst, input logic [1:0] v, tv, sv, input logic tr, sr);
    int w;
    logic done;
    logic [1:0] elig, ey;
    logic etv, esv;
    reset_i = rst; req_v_i = v; req_tag_v_i = tv; req_stat_v_i = sv;
    tag_mem_ready_i = tr; stat_mem_ready_i = sr;
    #2;
    done = m_issued == S;
    w = -1; ey = 2'b00; etv = 0; esv = 0; elig = 2'b00;
    if (!done) begin
      etv = tr && sr;
      esv = etv;
    end else begin
      for (int r = 0; r < 2; r++) elig[r] = v[r] && (!tv[r] || tr) && (!sv[r] || sr);
      if (elig[1] && (m_starve == LIM || !elig[0])) w = 1;
      else if (elig[0]) w = 0;
      if (w >= 0) begin
        ey[w] = 1'b1;
        etv = tv[w];
        esv = sv[w];
      end
    end
    a_y = req_yumi_o; a_tv = tag_mem_pkt_v_o; a_sv = stat_mem_pkt_v_o;
    if (!rst) begin
      chk("init_done", {63'b0, init_done_o}, {63'b0, done});
      chk("yumi", {62'b0, req_yumi_o}, {62'b0, ey});
      chk("tag_v", {63'b0, tag_mem_pkt_v_o}, {63'b0, etv});
      chk("stat_v", {63'b0, stat_mem_pkt_v_o}, {63'b0, esv});
      if (etv) chk("tag_pkt", 64'(tag_mem_pkt_o), done ? 64'(req_tag_pkt_i[w]) : 64'(m_issued) << TAG_SH);
      if (esv) chk("stat_pkt", 64'(stat_mem_pkt_o), done ? 64'(req_stat_pkt_i[w]) : 64'(m_issued) << STAT_SH);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_issued = 0;
      m_starve = 0;
    end else if (!done) m_issued += (tr && sr) ? 1 : 0;
    else if (w == 1 || !v[1]) m_starve = 0;
    else if (w == 0 && elig[1]) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
  endtask
  initial begin
    int n, stalled;
    req_tag_pkt_i = '0;
    req_stat_pkt_i = '0;
    tbl[0] = '{2'b01, 2'b01, 2'b01, 1, 1, 2'b01, 1, 1};
    tbl[1] = '{2'b10, 2'b10, 2'b00, 1, 1, 2'b10, 1, 0};
    tbl[2] = '{2'b11, 2'b11, 2'b11, 1, 1, 2'b01, 1, 1};
    tbl[3] = '{2'b11, 2'b01, 2'b01, 1, 0, 2'b10, 0, 0};
    tbl[4] = '{2'b11, 2'b11, 2'b01, 1, 0, 2'b10, 1, 0};
    tbl[5] = '{2'b01, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0};
    tbl[6] = '{2'b11, 2'b11, 2'b11, 0, 1, 2'b00, 0, 0};
    tbl[7] = '{2'b00, 2'b11, 2'b11, 1, 1, 2'b00, 0, 0};
    tbl[8] = '{2'b11, 2'b10, 2'b10, 1, 1, 2'b01, 0, 0};
    tbl[9] = '{2'b10, 2'b00, 2'b10, 0, 1, 2'b10, 0, 1};
    cycle(1, 2'b00, 2'b00, 2'b00, 0, 0);
    cycle(1, 2'b00, 2'b00, 2'b00, 0, 0);
    cycle(0, 2'b11, 2'b11, 2'b11, 0, 0);
    n = 0;
    while (!init_done_o && n < 200) begin
      cycle(0, 2'b11, 2'b11, 2'b11, 1, 1);
      n++;
    end
    chk("sweep_len", 64'(n), 64'd64);
    cycle(1, 2'b00, 2'b00, 2'b00, 1, 1);
    n = 0; stalled = 0;
    while (!init_done_o && n < 200) begin
      logic sr;
      sr = !(m_issued == 10 && stalled < 3);
      if (!sr) stalled++;
      cycle(0, 2'b00, 2'b00, 2'b00, 1, sr);
      n++;
    end
    chk("stall_sweep_len", 64'(n), 64'd67);
    cycle(1, 2'b00, 2'b00, 2'b00, 1, 1);
    n = 0;
    while (m_issued < 30 && n < 100) begin
      cycle(0, 2'b01, 2'b01, 2'b01, 1, 1);
      n++;
    end
    cycle(1, 2'b00, 2'b00, 2'b00, 1, 1);
    chk("rst_mid_done", {63'b0, init_done_o}, 64'd0);
    chk("rst_mid_idx", 64'(tag_mem_pkt_o[TW-3 -: 6]), 64'd0);
    n = 0;
    while (!init_done_o && n < 200) begin
      cycle(0, 2'b00, 2'b00, 2'b00, 1, 1);
      n++;
    end
    chk("resweep_len", 64'(n), 64'd64);
    for (int i = 0; i < 10; i++) begin
      rnd_pkts();
      cycle(0, tbl[i].v, tbl[i].tv, tbl[i].sv, tbl[i].tr, tbl[i].sr);
      chk($sformatf("tbl%0d_yumi", i), {62'b0, a_y}, {62'b0, tbl[i].y});
      chk($sformatf("tbl%0d_tv", i), {63'b0, a_tv}, {63'b0, tbl[i].etv});
      chk($sformatf("tbl%0d_sv", i), {63'b0, a_sv}, {63'b0, tbl[i].esv});
    end
    cycle(0, 2'b00, 2'b00, 2'b00, 1, 1);
    for (int k = 0; k < 15; k++) begin
      rnd_pkts();
      for (int r = 0; r < 2; r++) req_tag_pkt_i[r][TW-1 -: 2] = 2'(e_tag_set_tag);
      cycle(0, 2'b11, 2'b11, 2'b00, 1, 1);
      chk($sformatf("contend%0d", k), {62'b0, a_y}, (k % 5 == 4) ? 64'd2 : 64'd1);
    end
    for (int k = 0; k < 400; k++) begin
      rnd_pkts();
      cycle(0, 2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
